// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scanner: blank pattern, hex glyph table, width helper.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} indexed by nibble; b and d are lower case glyphs.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-register side and pin side of the scanner; master drives display data, slave drives the pins.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8,
  parameter int AN_W   = 4
);
  localparam int BANK_W = seg_pkg::clog2(DIGITS / AN_W);

  logic [4*DIGITS-1:0] hexs;
  logic [DIGITS-1:0]   point;
  logic [DIGITS-1:0]   les;
  logic [DIGITS-1:0]   blink;
  logic                lz_en;
  logic [3:0]          hexo;
  logic [6:0]          seg;
  logic                dp;
  logic [AN_W-1:0]     an;
  logic [BANK_W-1:0]   bank;
  logic                frame_tick;

  modport master (
    output hexs, point, les, blink, lz_en,
    input  hexo, seg, dp, an, bank, frame_tick
  );

  modport slave (
    input  hexs, point, les, blink, lz_en,
    output hexo, seg, dp, an, bank, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational nibble to active-low 7-segment decode; no state, no flow control.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TAB[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Self-timed 7-segment scanner with per-frame snapshot, dead time, blink and zero suppression.
// All pin outputs are registered one cycle after the (pc, idx) state they reflect; no backpressure.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int AN_W         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYC     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave io
);

  localparam int PC_W   = clog2(SCAN_DIV);
  localparam int IDX_W  = clog2(DIGITS);
  localparam int BC_W   = clog2(BLINK_FRAMES);
  localparam int BANK_W = clog2(DIGITS / AN_W);
  localparam int ANP_W  = clog2(AN_W);

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BC_W-1:0]     bc_q, bc_d;
  logic                bp_q, bp_d;
  logic [4*DIGITS-1:0] hex_sh_q, hex_sh_d;
  logic [DIGITS-1:0]   pt_sh_q, pt_sh_d;
  logic [DIGITS-1:0]   les_sh_q, les_sh_d;
  logic [DIGITS-1:0]   blk_sh_q, blk_sh_d;
  logic [DIGITS-1:0]   lzm_q, lzm_d;
  logic                bp_sh_q, bp_sh_d;

  logic [AN_W-1:0]     an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [3:0]          hexo_q, hexo_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                tick_q, tick_d;

  logic                load;
  logic                lead;
  logic [DIGITS-1:0]   lzm_new;
  logic [3:0]          nib;
  logic [6:0]          seg_dec;
  logic                dark;
  logic                lit;
  logic [ANP_W-1:0]    an_pos;

  assign load = (pc_q == '0) && (idx_q == '0);

  // Walk down from the top digit; the first nonzero nibble ends suppression, digit 0 always shows.
  always_comb begin
    lead    = io.lz_en;
    lzm_new = '0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (lead && (io.hexs[4*d +: 4] == 4'h0)) lzm_new[d] = 1'b1;
      else                                     lead       = 1'b0;
    end
  end

  always_comb begin
    pc_d     = pc_q + 1'b1;
    idx_d    = idx_q;
    bc_d     = bc_q;
    bp_d     = bp_q;
    hex_sh_d = hex_sh_q;
    pt_sh_d  = pt_sh_q;
    les_sh_d = les_sh_q;
    blk_sh_d = blk_sh_q;
    lzm_d    = lzm_q;
    bp_sh_d  = bp_sh_q;
    if (pc_q == PC_LAST) begin
      pc_d  = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      hex_sh_d = io.hexs;
      pt_sh_d  = io.point;
      les_sh_d = io.les;
      blk_sh_d = io.blink;
      lzm_d    = lzm_new;
      // The frame being loaded runs on the phase from before this load's toggle.
      bp_sh_d  = bp_q;
      if (bc_q == BC_LAST) begin
        bc_d = '0;
        bp_d = ~bp_q;
      end else begin
        bc_d = bc_q + 1'b1;
      end
    end
  end

  assign nib = hex_sh_q[{idx_q, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nib_i (nib),
    .seg_o (seg_dec)
  );

  always_comb begin
    dark   = les_sh_q[idx_q] | (blk_sh_q[idx_q] & bp_sh_q) | lzm_q[idx_q];
    lit    = (int'(pc_q) >= DEAD_CYC) && !dark;
    an_pos = ANP_W'(int'(idx_q) % AN_W);
    an_d   = '1;
    if (lit) an_d[an_pos] = 1'b0;
    seg_d  = lit ? seg_dec : SEG_OFF;
    dp_d   = lit ? ~pt_sh_q[idx_q] : 1'b1;
    hexo_d = nib;
    bank_d = BANK_W'(int'(idx_q) / AN_W);
    tick_d = load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      idx_q    <= '0;
      bc_q     <= '0;
      bp_q     <= 1'b0;
      hex_sh_q <= '0;
      pt_sh_q  <= '0;
      les_sh_q <= '0;
      blk_sh_q <= '0;
      lzm_q    <= '0;
      bp_sh_q  <= 1'b0;
      an_q     <= '1;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
      hexo_q   <= '0;
      bank_q   <= '0;
      tick_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      idx_q    <= idx_d;
      bc_q     <= bc_d;
      bp_q     <= bp_d;
      hex_sh_q <= hex_sh_d;
      pt_sh_q  <= pt_sh_d;
      les_sh_q <= les_sh_d;
      blk_sh_q <= blk_sh_d;
      lzm_q    <= lzm_d;
      bp_sh_q  <= bp_sh_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      hexo_q   <= hexo_d;
      bank_q   <= bank_d;
      tick_q   <= tick_d;
    end
  end

  assign io.an         = an_q;
  assign io.seg        = seg_q;
  assign io.dp         = dp_q;
  assign io.hexo       = hexo_q;
  assign io.bank       = bank_q;
  assign io.frame_tick = tick_q;

endmodule
